// File: rtl/boron_crypt_core.sv
// Boron block-cipher engine: iterative, one round per clock, encrypt or decrypt per block.
// Define BORON_KEY_CACHE_EN to cache the last round key so repeat-key decrypts skip KEYGEN.
module boron_crypt_core #(
    parameter int KEY_BITS   = 80,
    parameter int NUM_ROUNDS = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [KEY_BITS-1:0] in_key,
    input  logic [63:0]         in_text,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_text,
    output logic                busy
);
    // state  | meaning
    // IDLE   | waiting for a block
    // KEYGEN | decrypt only: run the forward schedule up to the last round key
    // ROUND  | one cipher round per cycle
    // FINAL  | last key whitening, result captured
    // DONE   | result held until the sink takes it
    localparam int CW = $clog2(NUM_ROUNDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_ROUNDS - 1);
    localparam logic [CW-1:0] ROUNDS_C = CW'(NUM_ROUNDS);
    localparam logic [63:0] SBOX  = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] ISBOX = 64'hA970_364B_D21C_8FE5;

    if (KEY_BITS != 80 && KEY_BITS != 128) begin : g_bad_key_bits
        $error("boron_crypt_core: KEY_BITS must be 80 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
        $error("boron_crypt_core: NUM_ROUNDS must be in 1..31");
    end

    typedef enum logic [2:0] {IDLE, KEYGEN, ROUND, FINAL, DONE} state_t;

    function automatic logic [63:0] enc_round(input logic [63:0] x);
        logic [63:0] y;
        logic [15:0] w0, w1, w2, w3;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = SBOX[{x[4*i +: 4], 2'b00} +: 4];
        w0 = y[15:0];
        w1 = {y[30:16], y[31]};
        w2 = {y[40:32], y[47:41]};
        w3 = {y[54:48], y[63:55]};
        w1 = w1 ^ w0;
        w3 = w3 ^ w2;
        return {w2, w1, w0, w3};
    endfunction

    function automatic logic [63:0] dec_round(input logic [63:0] x);
        logic [63:0] y, z;
        logic [15:0] w0, w1, w2, w3;
        w3 = x[15:0];
        w0 = x[31:16];
        w1 = x[47:32] ^ w0;
        w2 = x[63:48];
        w3 = w3 ^ w2;
        y = {w3[8:0], w3[15:9], w2[6:0], w2[15:7], w1[0], w1[15:1], w0};
        for (int i = 0; i < 16; i++) z[4*i +: 4] = ISBOX[{y[4*i +: 4], 2'b00} +: 4];
        return z;
    endfunction

    function automatic logic [KEY_BITS-1:0] fwd_sched(input logic [KEY_BITS-1:0] k,
                                                      input logic [4:0] rc);
        logic [KEY_BITS-1:0] r;
        r = {k[KEY_BITS-14:0], k[KEY_BITS-1:KEY_BITS-13]};
        r[3:0] = SBOX[{r[3:0], 2'b00} +: 4];
        if (KEY_BITS == 128) r[7:4] = SBOX[{r[7:4], 2'b00} +: 4];
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

    function automatic logic [KEY_BITS-1:0] inv_sched(input logic [KEY_BITS-1:0] k,
                                                      input logic [4:0] rc);
        logic [KEY_BITS-1:0] r;
        r = k;
        r[19:15] = r[19:15] ^ rc;
        r[3:0] = ISBOX[{r[3:0], 2'b00} +: 4];
        if (KEY_BITS == 128) r[7:4] = ISBOX[{r[7:4], 2'b00} +: 4];
        return {r[12:0], r[KEY_BITS-1:13]};
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [63:0]         s_q, s_d, out_q, out_d;
    logic [KEY_BITS-1:0] k_q, k_d;
    logic                mode_q, mode_d;
`ifdef BORON_KEY_CACHE_EN
    logic [KEY_BITS-1:0] mkey_q, mkey_d, cache_key_q, cache_key_d, cache_last_q, cache_last_d;
    logic                cache_vld_q, cache_vld_d, cache_hit;
    assign cache_hit = in_mode && cache_vld_q && (in_key == cache_key_q);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        k_d     = k_q;
        mode_d  = mode_q;
        out_d   = out_q;
`ifdef BORON_KEY_CACHE_EN
        mkey_d       = mkey_q;
        cache_key_d  = cache_key_q;
        cache_last_d = cache_last_q;
        cache_vld_d  = cache_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = in_text;
                    k_d     = in_key;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = in_mode ? KEYGEN : ROUND;
`ifdef BORON_KEY_CACHE_EN
                    mkey_d = in_key;
                    if (cache_hit) begin
                        k_d     = cache_last_q;
                        cnt_d   = ROUNDS_C;
                        state_d = ROUND;
                    end
`endif
                end
            end
            KEYGEN: begin
                k_d   = fwd_sched(k_q, 5'(cnt_q) + 5'd1);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ROUND;
`ifdef BORON_KEY_CACHE_EN
                    cache_key_d  = mkey_q;
                    cache_last_d = k_d;
                    cache_vld_d  = 1'b1;
`endif
                end
            end
            ROUND: begin
                if (!mode_q) begin
                    s_d   = enc_round(s_q ^ k_q[63:0]);
                    k_d   = fwd_sched(k_q, 5'(cnt_q) + 5'd1);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FINAL;
`ifdef BORON_KEY_CACHE_EN
                        cache_key_d  = mkey_q;
                        cache_last_d = k_d;
                        cache_vld_d  = 1'b1;
`endif
                    end
                end else begin
                    // walking the schedule backwards recovers the previous round key
                    s_d   = dec_round(s_q ^ k_q[63:0]);
                    k_d   = inv_sched(k_q, 5'(cnt_q));
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = FINAL;
                end
            end
            FINAL: begin
                s_d     = s_q ^ k_q[63:0];
                out_d   = s_q ^ k_q[63:0];
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

`ifdef BORON_KEY_CACHE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            mkey_q       <= '0;
            cache_key_q  <= '0;
            cache_last_q <= '0;
            cache_vld_q  <= 1'b0;
        end else begin
            mkey_q       <= mkey_d;
            cache_key_q  <= cache_key_d;
            cache_last_q <= cache_last_d;
            cache_vld_q  <= cache_vld_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE) && reset;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_text  = out_q;
endmodule
